// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
//   - opcode constants for the 16-bit, 4-bit-opcode CPU
//   - ALU operation constants
//   - ctrl_t: control bundle carried through ID/EX, EX/MEM, MEM/WB
//   - state_t: drain/halt FSM states
package ctrl_pkg;

   localparam int CTRL_ALU_W = 3;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LHB    = 4'hA;
   localparam logic [3:0] OP_LLB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam logic [CTRL_ALU_W-1:0] ALU_ADD    = 3'b000;
   localparam logic [CTRL_ALU_W-1:0] ALU_SUB    = 3'b001;
   localparam logic [CTRL_ALU_W-1:0] ALU_XOR    = 3'b010;
   localparam logic [CTRL_ALU_W-1:0] ALU_RED    = 3'b011;
   localparam logic [CTRL_ALU_W-1:0] ALU_SLL    = 3'b100;
   localparam logic [CTRL_ALU_W-1:0] ALU_SRA    = 3'b101;
   localparam logic [CTRL_ALU_W-1:0] ALU_ROR    = 3'b110;
   localparam logic [CTRL_ALU_W-1:0] ALU_PADDSB = 3'b111;

   typedef struct packed {
      logic                  jump;
      logic                  branch;
      logic                  memread;
      logic                  memtoreg;
      logic                  memwrite;
      logic                  alusrc;
      logic                  regwrite;
      logic                  halt;
      logic [CTRL_ALU_W-1:0] alu_op;
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> control bundle decode for the ID stage.
// Ports:
//   opcode   in   4-bit opcode
//   ctrl     out  control bundle
//   rs_used  out  instruction reads rs
//   rt_used  out  instruction reads rt
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl,
   output logic       rs_used,
   output logic       rt_used
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_ADD:    ctrl.alu_op = ALU_ADD;
         OP_SUB:    ctrl.alu_op = ALU_SUB;
         OP_XOR:    ctrl.alu_op = ALU_XOR;
         OP_RED:    ctrl.alu_op = ALU_RED;
         OP_SLL:    begin ctrl.alu_op = ALU_SLL; ctrl.alusrc = 1'b1; end
         OP_SRA:    begin ctrl.alu_op = ALU_SRA; ctrl.alusrc = 1'b1; end
         OP_ROR:    begin ctrl.alu_op = ALU_ROR; ctrl.alusrc = 1'b1; end
         OP_PADDSB: ctrl.alu_op = ALU_PADDSB;
         OP_LW: begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.alusrc   = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_op   = ALU_ADD;
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         OP_LHB, OP_LLB: begin
            ctrl.alu_op = ALU_ADD;
            ctrl.alusrc = 1'b1;
         end
         OP_B:      ctrl.branch = 1'b1;
         OP_BR: begin
            ctrl.branch = 1'b1;
            ctrl.jump   = 1'b1;
            ctrl.alusrc = 1'b1;
         end
         OP_HLT:    ctrl.halt = 1'b1;
         default:   ;  // PCS: only regwrite, set below
      endcase
      ctrl.regwrite = !(opcode inside {OP_SW, OP_B, OP_BR, OP_HLT});
      // rs: all ALU ops plus LW/SW address base, and BR target
      rs_used = (opcode <= OP_SW) || (opcode == OP_BR);
      // rt: two-operand ALU ops, and SW store data
      rt_used = (opcode <= OP_RED) || (opcode == OP_PADDSB) || (opcode == OP_SW);
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the five-stage datapath.
// Decodes in ID, carries valid/control/rd through EX, MEM and WB,
// detects load-use hazards, applies branch flushes, drains on HLT.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid, id_opcode         instruction in IF/ID
//   id_rs, id_rt, id_rd         register fields in ID
//   ex_br_taken                 branch resolved taken in EX
//   stall_o, flush_o            hold PC+IF/ID, squash IF/ID
//   ex_alu_op .. ex_jump        EX controls
//   mem_read, mem_write         MEM controls
//   wb_regwrite, wb_memtoreg    WB controls
//   wb_rd                       WB destination register
//   halted_o                    core halted (sticky until reset)
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_AW  = 4,
   parameter int ALU_OPW = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [3:0]         id_opcode,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic [REG_AW-1:0]  id_rd,
   input  logic               ex_br_taken,
   output logic               stall_o,
   output logic               flush_o,
   output logic [ALU_OPW-1:0] ex_alu_op,
   output logic               ex_alusrc,
   output logic               ex_branch,
   output logic               ex_jump,
   output logic               mem_read,
   output logic               mem_write,
   output logic               wb_regwrite,
   output logic               wb_memtoreg,
   output logic [REG_AW-1:0]  wb_rd,
   output logic               halted_o
);

   // stage 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB
   localparam int STAGES = 3;

   ctrl_t              dec;
   logic               rs_used, rt_used;
   logic [STAGES:1]    vld_pipe;
   ctrl_t              ctl_pipe [STAGES:1];
   logic [REG_AW-1:0]  rd_pipe  [STAGES:1];
   state_t             state, state_nxt;
   logic               hazard;
   logic               ins_vld;  // ID instruction enters EX at this edge

   ctrl_decode u_dec (
      .opcode  (id_opcode),
      .ctrl    (dec),
      .rs_used (rs_used),
      .rt_used (rt_used)
   );

   // Load-use: loaded value not available to the dependent instruction
   // until the load has left MEM; rd = 0 is the hardwired zero register.
   always_comb begin
      hazard = id_valid && vld_pipe[1] && ctl_pipe[1].memread &&
               (rd_pipe[1] != '0) &&
               ((rs_used && (id_rs == rd_pipe[1])) ||
                (rt_used && (id_rt == rd_pipe[1])));
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:    if (ins_vld && dec.halt) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (vld_pipe[STAGES] && ctl_pipe[STAGES].halt) state_nxt = ST_HALTED;
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_RUN;
      endcase
   end

   // FSM: outputs. Flush beats stall; outside RUN only bubbles enter EX.
   always_comb begin
      ins_vld  = (state == ST_RUN) && id_valid && !ex_br_taken && !hazard;
      stall_o  = (state != ST_RUN) || (hazard && !ex_br_taken);
      flush_o  = ex_br_taken && (state != ST_HALTED);
      halted_o = (state == ST_HALTED);
   end

   // Stage registers. Bubbles are stored as all-zero so a halted core
   // naturally settles to empty stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int s = 1; s <= STAGES; s++) begin
            ctl_pipe[s] <= '0;
            rd_pipe[s]  <= '0;
         end
      end else begin
         vld_pipe    <= {vld_pipe[STAGES-1:1], ins_vld};
         ctl_pipe[1] <= ins_vld ? dec   : '0;
         rd_pipe[1]  <= ins_vld ? id_rd : '0;
         for (int s = 2; s <= STAGES; s++) begin
            ctl_pipe[s] <= ctl_pipe[s-1];
            rd_pipe[s]  <= rd_pipe[s-1];
         end
      end
   end

   always_comb begin
      ex_alu_op   = vld_pipe[1] ? ALU_OPW'(ctl_pipe[1].alu_op) : '0;
      ex_alusrc   = vld_pipe[1] && ctl_pipe[1].alusrc;
      ex_branch   = vld_pipe[1] && ctl_pipe[1].branch;
      ex_jump     = vld_pipe[1] && ctl_pipe[1].jump;
      mem_read    = vld_pipe[2] && ctl_pipe[2].memread;
      mem_write   = vld_pipe[2] && ctl_pipe[2].memwrite;
      wb_regwrite = vld_pipe[3] && ctl_pipe[3].regwrite;
      wb_memtoreg = vld_pipe[3] && ctl_pipe[3].memtoreg;
      wb_rd       = vld_pipe[3] ? rd_pipe[3] : '0;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 16-bit, 4-bit-opcode CPU, replacing the single-cycle combinational decoder when the datapath moves to five stages (IF/ID/EX/MEM/WB). Decodes the opcode in ID and carries the control bundle and destination register through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and generates stall, applies branch flushes, and drains the pipeline on HLT through a three-state FSM. Sits between the IF/ID register and the datapath stage registers.

## Interface
- REG_AW, 4, register-address width
- ALU_OPW, 3, ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  4  opcode in ID
- id_rs, id_rt, id_rd  in  REG_AW each  source/destination register fields in ID
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle
- stall_o  out  1  hold PC and IF/ID this cycle
- flush_o  out  1  squash IF/ID this cycle (mirrors ex_br_taken while not HALTED)
- ex_alu_op  out  ALU_OPW  ALU operation for EX
- ex_alusrc, ex_branch, ex_jump  out  1 each  EX controls
- mem_read, mem_write  out  1 each  MEM controls
- wb_regwrite, wb_memtoreg  out  1 each  WB controls
- wb_rd  out  REG_AW  WB destination register
- halted_o  out  1  core halted; sticky until reset

## Operation
- Decode, ID: ALU ops 0x0–0x7 give alu_op = opcode[2:0], and ALUsrc is set for SLL/SRA/ROR. LW, SW, LHB and LLB give alu_op 000 with ALUsrc = 1. B gives Branch = 1; BR gives Branch = Jump = 1 with ALUsrc = 1. MemRead and MemToReg are set for LW; MemWrite for SW. RegWrite is set for every opcode except SW, B, BR and HLT. HLT raises an internal halt bit.
- Register use: rs is read by 0x0–0x9 and BR; rt is read by 0x0–0x3, PADDSB and SW.
- Every stage register carries valid, the control bundle, rd and halt. A bubble is valid = 0. All outputs are gated by the valid bit of their stage.
- Load-use hazard: EX valid, EX MemRead, EX rd != 0, and EX rd equals a used source register in ID. Result: stall_o = 1, IF/ID holds, and a bubble enters EX.
- Priority: flush > hazard stall > normal advance. On ex_br_taken, the ID instruction is replaced by a bubble and stall_o = 0.
- FSM states:
  - RUN: normal. A valid, unflushed HLT in ID enters EX at the edge and the FSM moves to DRAIN.
  - DRAIN: stall_o = 1, and bubbles are injected into EX while HLT proceeds through the stages. When HLT is valid in MEM/WB, the FSM moves to HALTED at the next edge.
  - HALTED: halted_o = 1 and stall_o = 1. All stage registers hold bubbles and outputs read 0. Only reset leaves this state.
- HLT in ID at the same time as ex_br_taken: HLT is squashed and the FSM stays in RUN.

## Timing
- Decode is combinational in ID. Controls appear in EX one edge after ID, in MEM after two, in WB after three.
- stall_o and flush_o are combinational in the same cycle as their cause.
- Load-use costs exactly one bubble. On the next cycle EX holds the bubble and the hazard clears.
- HLT accepted in ID at edge N: FSM is in DRAIN after edge N, and halted_o = 1 after edge N+3.
- Reset value of every stage valid, every control output, wb_rd, stall_o and halted_o is 0. FSM resets to RUN.
- Reset during DRAIN or HALTED returns to RUN with all stages empty.
- rd = 0 never causes a hazard.

## Structure
- Shared package ctrl_pkg holds the opcode constants (ADD..HLT), the ALU opcode constants, the control-bundle struct (jump, branch, memread, memtoreg, memwrite, alusrc, regwrite, halt, alu_op) and the FSM state enum.
- One sub-module, ctrl_decode: purely combinational mapping from opcode to control bundle plus rs_used/rt_used. It is reused by the verification reference model.

## Test plan
- Reset mid-stream: ADD (0x0, rd = 3) in ID, rst_n asserted → all outputs 0 immediately, FSM RUN. After release, ADD with rd = 3 gives wb_regwrite = 1 and wb_rd = 3 exactly 3 edges after ID.
- Load-use: LW rd = 5, then ADD rs = 5 → stall_o = 1 for one cycle, one bubble, ADD reaches EX one cycle late. Same sequence with rd = 0 → no stall.
- Flush: ex_br_taken = 1 while SW is in ID → flush_o = 1, SW never asserts mem_write.
- Halt: HLT in ID → stall_o high from the next cycle, halted_o = 1 three edges after acceptance. halted_o stays 1 for 20 cycles of arbitrary id_valid/opcode input.
- HLT in ID with ex_br_taken = 1 → HLT squashed, FSM stays RUN, halted_o stays 0.
- Decode sweep: opcodes 0x0–0xF in turn → EX/MEM/WB outputs match the ctrl_decode reference model, e.g. SLL gives alu_op = 100 with alusrc = 1, SW gives mem_write = 1 with regwrite = 0.
